// File: rtl/addr_pkg.sv
// Shared addressing-tuple definitions: field widths, field offsets, arbiter states
// and the dst/src group swap used to build reply addressing.
package addr_pkg;

    localparam int MAC_W   = 48;
    localparam int IP_W    = 32;
    localparam int PORT_W  = 16;
    localparam int TUPLE_W = 2 * (MAC_W + IP_W + PORT_W);

    // Field order from MSB: dst_mac, dst_ip, dst_port, src_mac, src_ip, src_port
    localparam int SRC_PORT_OFF = 0;
    localparam int SRC_IP_OFF   = SRC_PORT_OFF + PORT_W;
    localparam int SRC_MAC_OFF  = SRC_IP_OFF + IP_W;
    localparam int DST_PORT_OFF = SRC_MAC_OFF + MAC_W;
    localparam int DST_IP_OFF   = DST_PORT_OFF + PORT_W;
    localparam int DST_MAC_OFF  = DST_IP_OFF + IP_W;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    function automatic logic [TUPLE_W-1:0] swap_tuple(input logic [TUPLE_W-1:0] t);
        logic [TUPLE_W-1:0] r;
        r = t;
        r[DST_MAC_OFF  +: MAC_W]  = t[SRC_MAC_OFF  +: MAC_W];
        r[DST_IP_OFF   +: IP_W]   = t[SRC_IP_OFF   +: IP_W];
        r[DST_PORT_OFF +: PORT_W] = t[SRC_PORT_OFF +: PORT_W];
        r[SRC_MAC_OFF  +: MAC_W]  = t[DST_MAC_OFF  +: MAC_W];
        r[SRC_IP_OFF   +: IP_W]   = t[DST_IP_OFF   +: IP_W];
        r[SRC_PORT_OFF +: PORT_W] = t[DST_PORT_OFF +: PORT_W];
        return r;
    endfunction

endpackage

// File: rtl/addr_tuple_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo N_REQ. Returns one-hot grant plus its index.
module rr_arbiter #(
    parameter int N_REQ = 4,
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             valid
);

    logic [IDX_W-1:0] idx;

    // Walk the search order backwards so the closest request to ptr wins last
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        valid     = 1'b0;
        idx       = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = IDX_W'((int'(ptr) + k) % N_REQ);
            if (req[idx]) begin
                grant_idx = idx;
                valid     = 1'b1;
            end
        end
        if (valid) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/addr_tuple_arbiter.sv
// Round-robin arbiter sharing one header-address path between N_REQ parsers, with
// hold timeout and drop counter. Define ADDR_SWAP_EN to add swap_en (reply addressing).
module addr_tuple_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TUPLE_W = 192,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 16
) (
    input  logic                       clk,
    input  logic                       aresetn,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*TUPLE_W-1:0]   req_tuple,
`ifdef ADDR_SWAP_EN
    input  logic                       swap_en,
`endif
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [TUPLE_W-1:0]         out_tuple,
    output logic [$clog2(N_REQ)-1:0]   out_src_id,
    output logic                       drop_pulse,
    output logic [CNT_W-1:0]           drop_count
);
    import addr_pkg::*;

    localparam int ID_W    = $clog2(N_REQ);
    localparam int TIMER_W = $clog2(TIMEOUT);

    state_t               state, state_next;
    logic [ID_W-1:0]      rr_ptr;
    logic [TIMER_W-1:0]   timer;
    logic [N_REQ-1:0]     grant;
    logic [ID_W-1:0]      grant_idx;
    logic                 grant_valid;
    logic                 accept;
    logic                 expire;
    logic [TUPLE_W-1:0]   sel_tuple;
    logic [TUPLE_W-1:0]   latch_tuple;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .valid     (grant_valid)
    );

    assign sel_tuple = req_tuple[grant_idx * TUPLE_W +: TUPLE_W];

`ifdef ADDR_SWAP_EN
    assign latch_tuple = swap_en ? swap_tuple(sel_tuple) : sel_tuple;
`else
    assign latch_tuple = sel_tuple;
`endif

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // out_ready wins over expiry, so a tuple accepted on the last cycle is delivered
    always_comb begin
        state_next = state;
        req_ready  = '0;
        accept     = 1'b0;
        expire     = 1'b0;
        case (state)
            IDLE: begin
                req_ready = grant;
                if (grant_valid) begin
                    accept     = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_next = IDLE;
                end else if (timer == TIMER_W'(TIMEOUT - 1)) begin
                    expire     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign out_valid = (state == HOLD);

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            rr_ptr     <= '0;
            timer      <= '0;
            out_tuple  <= '0;
            out_src_id <= '0;
            drop_pulse <= 1'b0;
            drop_count <= '0;
        end else begin
            drop_pulse <= expire;
            if (accept) begin
                out_tuple  <= latch_tuple;
                out_src_id <= grant_idx;
                timer      <= '0;
                rr_ptr     <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
            end else if (state == HOLD && !out_ready && !expire) begin
                timer <= timer + 1'b1;
            end
            if (expire && drop_count != '1) begin
                drop_count <= drop_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_addr_tuple_arbiter.sv
// Randomised and directed bench for addr_tuple_arbiter against a cycle-level
// behavioural model of the grant / hold / timeout rules.
module tb_addr_tuple_arbiter;

    localparam int N  = 4;
    localparam int TW = 192;
    localparam int TO = 8;
    localparam int CW = 2;

    logic              clk = 1'b0;
    logic              aresetn;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*TW-1:0]   req_tuple;
    logic              out_valid;
    logic              out_ready;
    logic [TW-1:0]     out_tuple;
    logic [1:0]        out_src_id;
    logic              drop_pulse;
    logic [CW-1:0]     drop_count;
`ifdef ADDR_SWAP_EN
    logic              swap_en;
`endif

    int errors = 0;
    int checks = 0;

    bit            m_valid;
    logic [TW-1:0] m_tuple;
    int            m_src;
    int            m_ptr;
    int            m_age;
    int            m_drops;
    bit            m_pulse;
    int            grants_q[$];

    always #5 clk = ~clk;

    addr_tuple_arbiter #(
        .N_REQ   (N),
        .TUPLE_W (TW),
        .TIMEOUT (TO),
        .CNT_W   (CW)
    ) dut (
        .clk        (clk),
        .aresetn    (aresetn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_tuple  (req_tuple),
`ifdef ADDR_SWAP_EN
        .swap_en    (swap_en),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_tuple  (out_tuple),
        .out_src_id (out_src_id),
        .drop_pulse (drop_pulse),
        .drop_count (drop_count)
    );

    task automatic check(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [TW-1:0] rand_tuple();
        logic [TW-1:0] r;
        for (int i = 0; i < TW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic int pick();
        for (int k = 0; k < N; k++) begin
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 0;
        m_ptr   = 0;
        m_drops = 0;
        m_pulse = 0;
        m_age   = 0;
    endtask

    task automatic checkOutput();
        int            g;
        logic [N-1:0]  er;
        g  = pick();
        er = '0;
        if (!m_valid && g >= 0) er[g] = 1'b1;
        check("req_ready", TW'(req_ready), TW'(er));
        check("out_valid", TW'(out_valid), TW'(m_valid));
        if (m_valid) begin
            check("out_tuple", out_tuple, m_tuple);
            check("out_src_id", TW'(out_src_id), TW'(m_src));
        end
        check("drop_pulse", TW'(drop_pulse), TW'(m_pulse));
        check("drop_count", TW'(drop_count), TW'(m_drops));
    endtask

    task automatic model_step();
        int            g;
        logic [TW-1:0] t;
        m_pulse = 0;
        if (!m_valid) begin
            g = pick();
            if (g >= 0) begin
                t = req_tuple[g*TW +: TW];
`ifdef ADDR_SWAP_EN
                if (swap_en) t = {t[TW/2-1:0], t[TW-1:TW/2]};
`endif
                m_valid = 1;
                m_tuple = t;
                m_src   = g;
                m_ptr   = (g + 1) % N;
                m_age   = 0;
                grants_q.push_back(g);
            end
        end else if (out_ready) begin
            m_valid = 0;
        end else if (m_age == TO - 1) begin
            m_valid = 0;
            m_pulse = 1;
            if (m_drops < (1 << CW) - 1) m_drops++;
        end else begin
            m_age++;
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] v, input logic r, input int cycles);
        req_valid = v;
        out_ready = r;
        repeat (cycles) begin
            @(negedge clk);
            checkOutput();
            model_step();
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [TW-1:0] t2;
        logic [TW-1:0] a_half;

        aresetn   = 1'b0;
        req_valid = '0;
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) req_tuple[i*TW +: TW] = rand_tuple();
`ifdef ADDR_SWAP_EN
        swap_en = 1'b0;
`endif
        model_reset();
        #1;
        check("rst_out_valid", TW'(out_valid), TW'(0));
        check("rst_out_tuple", out_tuple, TW'(0));
        check("rst_out_src_id", TW'(out_src_id), TW'(0));
        check("rst_drop_pulse", TW'(drop_pulse), TW'(0));
        check("rst_drop_count", TW'(drop_count), TW'(0));
        check("rst_req_ready", TW'(req_ready), TW'(0));
        @(negedge clk);
        aresetn = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] single request");
        t2 = req_tuple[2*TW +: TW];
        applyStimulus(4'b0100, 1'b0, 1);
        check("single_tuple", out_tuple, t2);
        check("single_src", TW'(out_src_id), TW'(2));
        applyStimulus(4'b0000, 1'b1, 1);
        applyStimulus(4'b0000, 1'b0, 1);

        $display("[TB] pointer wrap");
        grants_q.delete();
        applyStimulus(4'b1001, 1'b1, 4);
        check("wrap_count", TW'(grants_q.size()), TW'(2));
        if (grants_q.size() >= 2) begin
            check("wrap_first", TW'(grants_q[0]), TW'(3));
            check("wrap_second", TW'(grants_q[1]), TW'(0));
        end

        $display("[TB] reset mid-hold");
        applyStimulus(4'b0010, 1'b0, 3);
        #2;
        aresetn = 1'b0;
        model_reset();
        #1;
        check("midrst_out_valid", TW'(out_valid), TW'(0));
        check("midrst_drop_count", TW'(drop_count), TW'(0));
        req_valid = '0;
        @(negedge clk);
        aresetn = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] fairness");
        grants_q.delete();
        applyStimulus(4'b1111, 1'b1, 10);
        check("fair_count", TW'(grants_q.size()), TW'(5));
        for (int i = 0; i < 5 && i < grants_q.size(); i++) begin
            check("fair_order", TW'(grants_q[i]), TW'(i % N));
        end
        applyStimulus(4'b0000, 1'b1, 1);

        $display("[TB] timeout");
        applyStimulus(4'b0001, 1'b0, 1);
        applyStimulus(4'b0000, 1'b0, TO);
        check("to_drop_pulse", TW'(drop_pulse), TW'(1));
        check("to_drop_count", TW'(drop_count), TW'(1));
        check("to_out_valid", TW'(out_valid), TW'(0));
        applyStimulus(4'b0000, 1'b0, 1);

        $display("[TB] ready at expiry");
        applyStimulus(4'b0001, 1'b0, 1);
        applyStimulus(4'b0000, 1'b0, TO - 1);
        applyStimulus(4'b0000, 1'b1, 1);
        check("tie_drop_pulse", TW'(drop_pulse), TW'(0));
        check("tie_drop_count", TW'(drop_count), TW'(1));
        check("tie_out_valid", TW'(out_valid), TW'(0));

        $display("[TB] drop counter saturation");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b0001, 1'b0, 1);
            applyStimulus(4'b0000, 1'b0, TO + 1);
        end
        check("sat_drop_count", TW'(drop_count), TW'(3));

`ifdef ADDR_SWAP_EN
        $display("[TB] address swap");
        a_half = rand_tuple();
        req_tuple[0 +: TW] = {a_half[TW-1:TW/2], t2[TW/2-1:0]};
        swap_en = 1'b1;
        applyStimulus(4'b0001, 1'b0, 1);
        swap_en = 1'b0;
        check("swap_tuple", out_tuple, {t2[TW/2-1:0], a_half[TW-1:TW/2]});
        applyStimulus(4'b0000, 1'b1, 1);
`else
        a_half = '0;
`endif

        $display("[TB] random traffic");
        for (int c = 0; c < 600; c++) begin
            logic r;
            for (int i = 0; i < N; i++) req_tuple[i*TW +: TW] = rand_tuple();
`ifdef ADDR_SWAP_EN
            swap_en = 1'($urandom_range(0, 1));
`endif
            if ((c / 60) % 2 == 0) r = ($urandom_range(0, 3) != 0);
            else                   r = ($urandom_range(0, 11) == 0);
            applyStimulus(N'($urandom_range(0, (1 << N) - 1)), r, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
